wos_job_sequencer: RTL
======================

WOS_JOB_SEQUENCER -- requirements
Module: wos_job_sequencer

Interface
REQ-001 SHALL have parameter WORD, default 8, which is the width of the h, w and n operands.
REQ-002 SHALL have parameter MAX_N, default 25, which is the largest legal kernel size.
REQ-003 SHALL have parameter TO_W, default 16, which is the width of the watchdog counter.
REQ-004 Ports SHALL be exactly as listed, in this order.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  3  register index.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  read data, combinational from cfg_addr.
- eng_h, eng_w, eng_n  out  WORD each  job geometry driven to the address generator.
- eng_run  out  1  launch pulse to the address generator.
- eng_w_en  in  1  one result-pixel write per cycle high.
- irq  out  1  level interrupt.

Function
REQ-005 Register map SHALL be:
- 0 CTRL: bit0 START (write-1 pulse), bit1 IRQ_EN, bit2 ABORT (write-1 pulse).
- 1 STATUS: bit0 BUSY (RO), bit1 DONE, bit2 CFG_ERR, bit3 TIMEOUT, bit4 ABORTED; bits1-4 sticky, write-1-to-clear.
- 2 H, 3 W, 4 N: WORD bits each, zero-extended on read.
- 5 WCOUNT (RO): writes counted in the current or last job.
- 6 TO_LIMIT: TO_W bits.
- 7: reads 0.
REQ-006 Writes to H, W, N and TO_LIMIT while BUSY SHALL be ignored.
REQ-007 eng_h, eng_w and eng_n SHALL be driven from shadow copies latched in CHECK, so they stay stable for the whole job.
REQ-008 FSM states SHALL be IDLE, CHECK, LAUNCH, RUN and DONE; BUSY = (state != IDLE).
REQ-009 IDLE: START written SHALL cause IDLE->CHECK on the next edge; START written while not IDLE SHALL be ignored.
REQ-010 CHECK (1 cycle) SHALL latch the shadows, clear WCOUNT and the watchdog, then go:
- to IDLE with CFG_ERR set if h<1, w<1, n even, n<1 or n>MAX_N (h, w, n treated as signed WORD);
- otherwise to LAUNCH.
REQ-011 LAUNCH SHALL hold eng_run=1 for exactly 2 cycles, then go to RUN; eng_run SHALL be 0 in every other state.
REQ-012 RUN: each cycle with eng_w_en=1 SHALL increment WCOUNT; target = h*w, computed as a 2*WORD-bit unsigned product in CHECK.
REQ-013 RUN SHALL go to DONE on the edge where WCOUNT reaches target, counting the eng_w_en of that cycle.
REQ-014 DONE (1 cycle) SHALL set the DONE status bit, then go to IDLE.
REQ-015 eng_w_en seen outside RUN SHALL be ignored and SHALL NOT change WCOUNT.
REQ-016 Watchdog in RUN:
- counts cycles since the last eng_w_en and resets to 0 on each eng_w_en;
- when the count equals TO_LIMIT with TO_LIMIT!=0: set TIMEOUT and go to IDLE;
- TO_LIMIT=0 disables the watchdog.
REQ-017 ABORT written in any non-IDLE state SHALL force IDLE on the next edge, set ABORTED and drop eng_run; ABORT written in IDLE SHALL be a no-op.
REQ-018 Simultaneous events:
- ABORT SHALL win over reaching target and over timeout;
- reaching target SHALL win over timeout.
REQ-019 A W1C write to a status bit in the same cycle as that bit is set SHALL leave the bit set.
REQ-020 irq SHALL equal IRQ_EN & (DONE|CFG_ERR|TIMEOUT|ABORTED), registered, i.e. 1 cycle after the status bit is set.
REQ-021 WCOUNT SHALL be 2*WORD bits, SHALL saturate at all-ones, and SHALL NOT wrap.

Reset
REQ-022 On rst=1 at a clock edge SHALL set: state=IDLE, all registers and shadows 0, WCOUNT 0, watchdog 0, eng_run 0, irq 0, status 0.
REQ-023 rst asserted mid-job SHALL abort with no ABORTED flag and SHALL take priority over every event in the same cycle.

Structure
REQ-024 A shared package SHALL hold the state encoding, register indices, STATUS/CTRL bit positions and the default WORD/MAX_N.
REQ-025 Sub-module wos_cfg_regs SHALL contain the register file and W1C logic; the FSM, counters and watchdog SHALL live in the top module.

Verification
REQ-026 Bench SHALL cover these scenarios:
- H=4, W=4, N=3, START; drive 16 eng_w_en pulses -> eng_run high 2 cycles after CHECK; DONE set on 16th pulse edge; WCOUNT=16; irq 1 cycle later with IRQ_EN=1.
- N=4, START -> CFG_ERR=1 two cycles after write; eng_run never asserts; BUSY back to 0.
- TO_LIMIT=5, job started, eng_w_en held 0 -> TIMEOUT set when the idle count reaches 5; IDLE; eng_w_en then ignored.
- ABORT written in the same cycle as the final eng_w_en -> ABORTED=1, DONE=0.
- Write H=9 while BUSY -> H reads the old value; START while BUSY -> no restart and WCOUNT is not cleared.
- rst pulsed during RUN -> all outputs and STATUS 0 on the next cycle; a fresh job afterwards completes normally.

Source files
------------

// File: rtl/wos_job_sequencer_pkg.sv
// Shared definitions for the job sequencer: FSM encoding, register map
// indices, CTRL/STATUS bit positions and default geometry parameters.
package wos_job_sequencer_pkg;

  localparam int WORD_DEF  = 8;
  localparam int MAX_N_DEF = 25;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_STATUS   = 3'd1;
  localparam logic [2:0] A_H        = 3'd2;
  localparam logic [2:0] A_W        = 3'd3;
  localparam logic [2:0] A_N        = 3'd4;
  localparam logic [2:0] A_WCOUNT   = 3'd5;
  localparam logic [2:0] A_TO_LIMIT = 3'd6;

  localparam int C_START  = 0;
  localparam int C_IRQ_EN = 1;
  localparam int C_ABORT  = 2;

  localparam int B_BUSY    = 0;
  localparam int B_DONE    = 1;
  localparam int B_CFG_ERR = 2;
  localparam int B_TIMEOUT = 3;
  localparam int B_ABORTED = 4;

endpackage

// File: rtl/wos_cfg_regs.sv
// Register file for the job sequencer.
//   cfg_*      : host register port, cfg_rdata is combinational from cfg_addr
//   busy       : job in flight; blocks geometry/TO_LIMIT writes, read as STATUS.BUSY
//   wcount     : live write counter, read back as WCOUNT
//   st_set     : sticky STATUS set requests from the FSM (bits 4:1)
//   start_p / abort_p : one-cycle CTRL command pulses
//   reg_h/w/n, to_limit : programmed job parameters
//   irq        : registered IRQ_EN & any sticky status bit
module wos_cfg_regs
  import wos_job_sequencer_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int TO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  input  logic              busy,
  input  logic [2*WORD-1:0] wcount,
  input  logic [4:1]        st_set,
  output logic              start_p,
  output logic              abort_p,
  output logic [WORD-1:0]   reg_h,
  output logic [WORD-1:0]   reg_w,
  output logic [WORD-1:0]   reg_n,
  output logic [TO_W-1:0]   to_limit,
  output logic              irq
);

  logic       irq_en;
  logic [4:1] sticky;
  logic [4:1] st_clr;
  logic       wr_ctrl;
  logic       unused_wdata;

  assign unused_wdata = ^cfg_wdata;
  assign wr_ctrl = cfg_we && (cfg_addr == A_CTRL);
  assign start_p = wr_ctrl && cfg_wdata[C_START];
  assign abort_p = wr_ctrl && cfg_wdata[C_ABORT];
  assign st_clr  = (cfg_we && cfg_addr == A_STATUS) ? cfg_wdata[4:1] : 4'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en   <= 1'b0;
      sticky   <= '0;
      reg_h    <= '0;
      reg_w    <= '0;
      reg_n    <= '0;
      to_limit <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= cfg_wdata[C_IRQ_EN];
      if (cfg_we && !busy) begin
        case (cfg_addr)
          A_H:        reg_h    <= cfg_wdata[WORD-1:0];
          A_W:        reg_w    <= cfg_wdata[WORD-1:0];
          A_N:        reg_n    <= cfg_wdata[WORD-1:0];
          A_TO_LIMIT: to_limit <= cfg_wdata[TO_W-1:0];
          default: ;
        endcase
      end
      // set beats clear when both land on the same bit
      sticky <= (sticky & ~st_clr) | st_set;
      irq    <= irq_en & (|sticky);
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      A_CTRL:     cfg_rdata[C_IRQ_EN]    = irq_en;
      A_STATUS:   cfg_rdata[4:0]         = {sticky, busy};
      A_H:        cfg_rdata[WORD-1:0]    = reg_h;
      A_W:        cfg_rdata[WORD-1:0]    = reg_w;
      A_N:        cfg_rdata[WORD-1:0]    = reg_n;
      A_WCOUNT:   cfg_rdata[2*WORD-1:0]  = wcount;
      A_TO_LIMIT: cfg_rdata[TO_W-1:0]    = to_limit;
      default:    cfg_rdata = '0;
    endcase
  end

endmodule

// File: rtl/wos_job_sequencer.sv
// Job sequencer: validates a programmed h/w/n job, launches the address
// generator, counts result writes to h*w and guards the job with a watchdog.
//   clk, rst          : clock, synchronous active-high reset
//   cfg_*             : register port (see wos_cfg_regs)
//   eng_h/w/n         : job geometry, held from shadows for the whole job
//   eng_run           : two-cycle launch pulse
//   eng_w_en          : one result write per high cycle
//   irq               : level interrupt
module wos_job_sequencer
  import wos_job_sequencer_pkg::*;
#(
  parameter int WORD  = WORD_DEF,
  parameter int MAX_N = MAX_N_DEF,
  parameter int TO_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  output logic [WORD-1:0] eng_h,
  output logic [WORD-1:0] eng_w,
  output logic [WORD-1:0] eng_n,
  output logic            eng_run,
  input  logic            eng_w_en,
  output logic            irq
);

  localparam logic signed [WORD-1:0] ONE  = WORD'(1);
  localparam logic signed [WORD-1:0] NMAX = WORD'(MAX_N);

  state_t              state, state_n;
  logic                busy, start_p, abort_p, launch_cnt;
  logic [4:1]          st_set;
  logic [WORD-1:0]     reg_h, reg_w, reg_n;
  logic [TO_W-1:0]     to_limit, wd;
  logic [2*WORD-1:0]   target, wcount, wc_inc;
  logic signed [WORD-1:0] hs, ws, ns;
  logic                cfg_bad, hit, tmo;

  assign busy    = (state != IDLE);
  assign eng_run = (state == LAUNCH);

  wos_cfg_regs #(.WORD(WORD), .TO_W(TO_W)) u_regs (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .busy(busy),
    .wcount(wcount), .st_set(st_set), .start_p(start_p), .abort_p(abort_p),
    .reg_h(reg_h), .reg_w(reg_w), .reg_n(reg_n), .to_limit(to_limit), .irq(irq)
  );

  // geometry is judged as signed so a wrapped "negative" size is rejected
  assign hs = reg_h;
  assign ws = reg_w;
  assign ns = reg_n;
  assign cfg_bad = (hs < ONE) || (ws < ONE) || (ns < ONE) || (ns > NMAX) || !reg_n[0];

  assign wc_inc = (&wcount) ? wcount : wcount + 1'b1;
  assign hit    = eng_w_en && (wc_inc == target);
  assign tmo    = (to_limit != '0) && (wd == to_limit);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // priority inside RUN: abort > target reached > watchdog
  always_comb begin
    state_n = state;
    st_set  = '0;
    case (state)
      IDLE:   if (start_p) state_n = CHECK;
      CHECK:  if (cfg_bad) begin
                state_n = IDLE;
                st_set[B_CFG_ERR] = 1'b1;
              end else state_n = LAUNCH;
      LAUNCH: if (launch_cnt) state_n = RUN;
      RUN:    if (hit) begin
                state_n = DONE;
                st_set[B_DONE] = 1'b1;
              end else if (tmo) begin
                state_n = IDLE;
                st_set[B_TIMEOUT] = 1'b1;
              end
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_p && state != IDLE) begin
      state_n = IDLE;
      st_set  = '0;
      st_set[B_ABORTED] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eng_h      <= '0;
      eng_w      <= '0;
      eng_n      <= '0;
      target     <= '0;
      wcount     <= '0;
      wd         <= '0;
      launch_cnt <= 1'b0;
    end else begin
      launch_cnt <= (state == LAUNCH) ? ~launch_cnt : 1'b0;
      if (state == CHECK) begin
        eng_h  <= reg_h;
        eng_w  <= reg_w;
        eng_n  <= reg_n;
        target <= (2*WORD)'(reg_h) * (2*WORD)'(reg_w);
        wcount <= '0;
        wd     <= '0;
      end else if (state == RUN && !abort_p) begin
        if (eng_w_en) begin
          wcount <= wc_inc;
          wd     <= '0;
        end else begin
          wd <= wd + 1'b1;
        end
      end
    end
  end

endmodule
